// File: rtl/tpu_pkg.sv
// tpu_pkg: shared drain FSM state encoding and default datapath widths
package tpu_pkg;
  localparam int SIZE_DEF = 8;
  localparam int PSW_DEF = 45;
  localparam int OUT_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 10;
  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT, FINISH} state_t;
endpackage

// File: rtl/quant_lane.sv
// quant_lane: round-half-up right shift then saturate one partial sum (psum, shift -> q); RELU_EN clamps negatives to 0
module quant_lane import tpu_pkg::*; #(
  parameter int PARTIAL_SUM_WIDTH = PSW_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic [PARTIAL_SUM_WIDTH-1:0] psum,
  input  logic [4:0]                   shift,
  output logic [OUT_WIDTH-1:0]         q
);
  localparam int PW = PARTIAL_SUM_WIDTH;
  localparam logic signed [PW:0] HI = (PW+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
`ifdef RELU_EN
  localparam logic signed [PW:0] LO = '0;
`else
  localparam logic signed [PW:0] LO = -HI - 1;
`endif
  logic signed [PW:0] ext, rnd, shd;
  always_comb begin
    ext = {psum[PW-1], psum};
    rnd = shift == 5'd0 ? ext : ext + ((PW+1)'(1) << (shift - 5'd1));
    shd = rnd >>> shift;
    q = shd > HI ? HI[OUT_WIDTH-1:0] : shd < LO ? LO[OUT_WIDTH-1:0] : shd[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/output_quantizer.sv
// output_quantizer: snapshot SIZE accumulator lanes and stream quantized values to the output buffer (clk, rst, Drain_start/Psum_in/Shift/Base_addr in; Cal_hold, Wr_valid/Wr_addr/Wr_data, Done out; Wr_ready in); RELU_EN selects ReLU saturation
module output_quantizer import tpu_pkg::*; #(
  parameter int SIZE = SIZE_DEF,
  parameter int PARTIAL_SUM_WIDTH = PSW_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Drain_start,
  input  logic [SIZE*PARTIAL_SUM_WIDTH-1:0] Psum_in,
  input  logic [4:0]                        Shift,
  input  logic [ADDR_WIDTH-1:0]             Base_addr,
  output logic                              Cal_hold,
  output logic                              Wr_valid,
  input  logic                              Wr_ready,
  output logic [ADDR_WIDTH-1:0]             Wr_addr,
  output logic [OUT_WIDTH-1:0]              Wr_data,
  output logic                              Done
);
  localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;
  state_t state, state_n;
  logic [SIZE-1:0][PARTIAL_SUM_WIDTH-1:0] bank;
  logic [4:0] shift_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [CW-1:0] cnt, nxt, sel;
  logic last, ld;
  logic [OUT_WIDTH-1:0] q;
  assign last = cnt == CW'(SIZE-1);
  assign nxt = cnt + 1'b1;
  // quantizer looks at the lane about to be loaded: current lane on first load, next lane on a back-to-back advance
  assign sel = Wr_valid && !last ? nxt : cnt;
  assign ld = state == EMIT && (!Wr_valid || (Wr_ready && !last));
  assign Cal_hold = state != IDLE;
  assign Done = state == FINISH;
  quant_lane #(.PARTIAL_SUM_WIDTH(PARTIAL_SUM_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_quant (
    .psum (bank[sel]),
    .shift(shift_r),
    .q    (q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (Drain_start ? CAPTURE : IDLE) :
              state == CAPTURE ? EMIT :
              state == EMIT ? (Wr_valid && Wr_ready && last ? FINISH : EMIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bank <= '0;
      shift_r <= '0;
      base_r <= '0;
      cnt <= '0;
      Wr_valid <= 1'b0;
      Wr_addr <= '0;
      Wr_data <= '0;
    end else begin
      if (state == IDLE && Drain_start) begin
        shift_r <= Shift;
        base_r <= Base_addr;
      end
      if (state == CAPTURE) begin
        bank <= Psum_in;
        cnt <= '0;
      end
      if (ld) begin
        Wr_valid <= 1'b1;
        Wr_data <= q;
        Wr_addr <= base_r + ADDR_WIDTH'(sel);
        cnt <= sel;
      end else if (state == EMIT && Wr_valid && Wr_ready && last) Wr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_output_quantizer.sv
// tb_output_quantizer: vector table, directed drain sequences and randomized passes against an arithmetic model
module tb_output_quantizer;
  localparam int SIZE = 8, PSW = 45, OW = 8, AW = 10;
  logic clk = 1'b0, rst, Drain_start, Wr_ready, Cal_hold, Wr_valid, Done;
  logic [SIZE*PSW-1:0] Psum_in;
  logic [4:0] Shift;
  logic [AW-1:0] Base_addr, Wr_addr;
  logic [OW-1:0] Wr_data;
  always #5 clk = ~clk;
  output_quantizer dut (
    .clk(clk), .rst(rst), .Drain_start(Drain_start), .Psum_in(Psum_in), .Shift(Shift),
    .Base_addr(Base_addr), .Cal_hold(Cal_hold), .Wr_valid(Wr_valid), .Wr_ready(Wr_ready),
    .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Done(Done)
  );
  int tests = 0, fails = 0, cyc = 0;
  logic [PSW-1:0] lanes [SIZE];
  int sh, base;
  int acc_addr[$], acc_cyc[$], done_cyc[$], fv_cyc[$];
  longint acc_data[$];
  logic pv = 1'b0;
  typedef struct {longint psum; int sh; longint exp;} qv_t;
  qv_t tbl[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (Wr_valid && Wr_ready) begin
      acc_addr.push_back(int'(Wr_addr));
      acc_data.push_back(longint'($signed(Wr_data)));
      acc_cyc.push_back(cyc);
    end
    if (Done) done_cyc.push_back(cyc);
    if (Wr_valid && !pv) fv_cyc.push_back(cyc);
    pv <= Wr_valid;
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic longint relu_exp(input longint e);
`ifdef RELU_EN
    return e < 0 ? 0 : e;
`else
    return e;
`endif
  endfunction
  function automatic longint model(input logic [PSW-1:0] x, input int s);
    logic signed [PSW-1:0] t;
    longint v, hi, lo;
    t = x;
    v = t;
    if (s > 0) v = (v + (longint'(1) <<< (s - 1))) >>> s;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = relu_exp(-hi - 1);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic [PSW-1:0] rnd_val(input int bits);
    longint m;
    m = {$urandom, $urandom};
    return PSW'(m >>> (63 - bits));
  endfunction
  task automatic pack();
    for (int i = 0; i < SIZE; i++) Psum_in[i*PSW +: PSW] = lanes[i];
  endtask
  task automatic clear_q();
    acc_addr.delete(); acc_data.delete(); acc_cyc.delete(); done_cyc.delete(); fv_cyc.delete();
  endtask
  task automatic run_pass(input int mode, input int stall_lane, input bit scramble, input bit repulse);
    int n, stalls, ds;
    stalls = 3;
    @(posedge clk); #1;
    clear_q();
    pack();
    Shift = 5'(sh);
    Base_addr = AW'(base);
    Drain_start = 1'b1;
    Wr_ready = 1'b1;
    ds = cyc;
    @(posedge clk); #1;
    Drain_start = 1'b0;
    Shift = 5'($urandom);
    Base_addr = AW'($urandom);
    n = 0;
    while (done_cyc.size() == 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("cal_hold_busy", Cal_hold, 1);
      if (scramble) for (int i = 0; i < SIZE; i++) Psum_in[i*PSW +: PSW] = PSW'({$urandom, $urandom});
      Drain_start = repulse && n == 4;
      if (mode == 1) Wr_ready = 1'($urandom);
      else if (mode == 2 && Wr_valid && acc_addr.size() == stall_lane && stalls > 0) begin
        Wr_ready = 1'b0;
        stalls--;
        @(negedge clk);
        chk("stall_addr", Wr_addr, (base + stall_lane) % 1024);
        chk("stall_data", longint'($signed(Wr_data)), model(lanes[stall_lane], sh));
      end else Wr_ready = 1'b1;
    end
    Drain_start = 1'b0;
    chk("done_seen", done_cyc.size() > 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("write_count", acc_addr.size(), SIZE);
    for (int i = 0; i < acc_addr.size() && i < SIZE; i++) begin
      chk("addr", acc_addr[i], (base + i) % 1024);
      chk("data", acc_data[i], model(lanes[i], sh));
    end
    chk("done_pulses", done_cyc.size(), 1);
    if (acc_cyc.size() == SIZE && done_cyc.size() > 0) chk("done_timing", done_cyc[0], acc_cyc[SIZE-1] + 1);
    if (fv_cyc.size() > 0) chk("first_valid", fv_cyc[0], ds + 3);
    chk("cal_hold_idle", Cal_hold, 0);
  endtask
  initial begin
    int n;
    rst = 1'b1; Drain_start = 1'b0; Wr_ready = 1'b0; Psum_in = '0; Shift = '0; Base_addr = '0;
    #12;
    chk("rst_valid", Wr_valid, 0);
    chk("rst_data", Wr_data, 0);
    chk("rst_addr", Wr_addr, 0);
    chk("rst_done", Done, 0);
    chk("rst_cal_hold", Cal_hold, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tbl.push_back('{40, 4, 3});
    tbl.push_back('{-40, 4, -2});
    tbl.push_back('{24, 4, 2});
    tbl.push_back('{23, 4, 1});
    tbl.push_back('{-24, 4, -1});
    tbl.push_back('{-25, 4, -2});
    tbl.push_back('{1000, 0, 127});
    tbl.push_back('{-1000, 0, -128});
    tbl.push_back('{127, 0, 127});
    tbl.push_back('{128, 0, 127});
    tbl.push_back('{-128, 0, -128});
    tbl.push_back('{-129, 0, -128});
    tbl.push_back('{2039, 4, 127});
    tbl.push_back('{2040, 4, 127});
    tbl.push_back('{-2056, 4, -128});
    tbl.push_back('{-2057, 4, -128});
    tbl.push_back('{64'sd17592186044415, 1, 127});
    tbl.push_back('{64'sd17592186044415, 31, 127});
    tbl.push_back('{-64'sd17592186044416, 31, -128});
    tbl.push_back('{5, 31, 0});
    foreach (tbl[k]) begin
      lanes[0] = PSW'(tbl[k].psum);
      for (int i = 1; i < SIZE; i++) lanes[i] = rnd_val($urandom_range(12, 0));
      sh = tbl[k].sh;
      base = $urandom_range(1023, 0);
      run_pass(0, 0, 1'b0, 1'b0);
      if (acc_data.size() > 0) chk("tbl_lane0", acc_data[0], relu_exp(tbl[k].exp));
    end
    for (int i = 0; i < SIZE; i++) lanes[i] = rnd_val(10);
    lanes[0] = PSW'(40);
    sh = 4; base = 'h100;
    run_pass(0, 0, 1'b0, 1'b0);
    sh = 2;
    run_pass(2, 2, 1'b0, 1'b0);
    sh = 5; base = 'h2A0;
    run_pass(0, 0, 1'b1, 1'b1);
    sh = 1; base = 'h3FE;
    run_pass(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < SIZE; i++) lanes[i] = rnd_val(12);
    sh = 3; base = 'h20;
    @(posedge clk); #1;
    clear_q();
    pack();
    Shift = 5'(sh); Base_addr = AW'(base); Drain_start = 1'b1; Wr_ready = 1'b1;
    @(posedge clk); #1;
    Drain_start = 1'b0;
    n = 0;
    while (acc_addr.size() < 5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reach_lane5", acc_addr.size(), 5);
    rst = 1'b1;
    #1;
    chk("midrst_valid", Wr_valid, 0);
    chk("midrst_cal_hold", Cal_hold, 0);
    chk("midrst_done", Done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_writes", acc_addr.size(), 5);
    chk("midrst_no_done", done_cyc.size(), 0);
    run_pass(0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < SIZE; i++) lanes[i] = rnd_val(($urandom_range(7, 0) == 0) ? 44 : $urandom_range(20, 0));
      sh = $urandom_range(16, 0);
      base = $urandom_range(1023, 0);
      run_pass(1, 0, 1'($urandom), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
